// File: rtl/key_evt_master.sv
// key_evt_master
// Avalon-MM initiator for the 4-bit key PIO. On irq it reads the
// edge-capture register, clears it, samples the live key levels and queues
// the result as an event in a small valid/ready FIFO.
// Bus outputs are registered for the state being entered, so a read address
// is already on the bus while the FSM sits in CAP_A / DAT_A and the PIO's
// registered read data is ready when the FSM reaches CAP_D / DAT_D.
// Optional feature: define KEY_EVT_TIMESTAMP_EN to add a free-running 16-bit
// cycle counter whose value at CAP_D travels with each event on evt_time.
module key_evt_master #(
    parameter int               KEY_W      = 4,
    parameter logic [KEY_W-1:0] MASK_INIT  = 4'hF,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             irq,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             mask_wr,
    input  logic [KEY_W-1:0] mask_data,
    output logic             mask_busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KEY_W-1:0] evt_edges,
    output logic [KEY_W-1:0] evt_level
`ifdef KEY_EVT_TIMESTAMP_EN
    ,
    output logic [15:0]      evt_time
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef KEY_EVT_TIMESTAMP_EN
    localparam int ENTRY_W = 2 * KEY_W + 16;
`else
    localparam int ENTRY_W = 2 * KEY_W;
`endif

    typedef enum logic [3:0] {
        INIT, IDLE, MASK, CAP_A, CAP_D, CLR, DAT_A, DAT_D, PUSH
    } state_t;

    state_t             state;
    logic               mask_pend;
    logic [KEY_W-1:0]   mask_lat;
    logic [KEY_W-1:0]   edges_r;
    logic [KEY_W-1:0]   levels_r;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               fifo_full;
    logic               do_push;
    logic               do_pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Upper read-data bits are not used by a KEY_W-wide PIO.
    logic               unused_rd;
    assign unused_rd = ^avm_readdata[31:KEY_W];

`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_r;

    // Free-running cycle counter; wraps naturally at 16'hFFFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= 16'd0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end

    // Timestamp is taken together with the edge-capture read.
    always_ff @(posedge clk) begin
        if (state == CAP_D) begin
            ts_r <= ts_cnt;
        end
    end

    assign push_entry = {ts_r, edges_r, levels_r};
    assign evt_time   = evt_valid ? head_entry[2*KEY_W +: 16] : 16'd0;
`else
    assign push_entry = {edges_r, levels_r};
`endif

    // Control FSM: sequences the PIO accesses and latches mask requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 2'd0;
            avm_writedata  <= 32'd0;
            mask_pend      <= 1'b0;
            mask_lat       <= '0;
        end else begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            // A new pulse always wins over an older, unserviced one.
            if (mask_wr) begin
                mask_pend <= 1'b1;
                mask_lat  <= mask_data;
            end
            case (state)
                INIT: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= 2'd2;
                    avm_writedata  <= 32'(MASK_INIT);
                    state          <= IDLE;
                end
                IDLE: begin
                    // A request arriving this very cycle is serviced with its own data.
                    if (mask_pend || mask_wr) begin
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= 2'd2;
                        avm_writedata  <= 32'(mask_wr ? mask_data : mask_lat);
                        state          <= MASK;
                    end else if (irq && !fifo_full) begin
                        avm_address <= 2'd3;
                        state       <= CAP_A;
                    end
                end
                MASK: begin
                    // Keep a pulse that lands during MASK pending for another pass.
                    mask_pend <= mask_wr;
                    state     <= IDLE;
                end
                CAP_A: state <= CAP_D;
                CAP_D: begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= 2'd3;
                    avm_writedata  <= 32'd0;
                    state          <= CLR;
                end
                CLR: begin
                    avm_address <= 2'd0;
                    state       <= DAT_A;
                end
                DAT_A:   state <= DAT_D;
                DAT_D:   state <= PUSH;
                PUSH:    state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

    assign mask_busy = mask_pend;

    // Read-data capture into the event payload registers.
    always_ff @(posedge clk) begin
        if (state == CAP_D) begin
            edges_r <= avm_readdata[KEY_W-1:0];
        end
        if (state == DAT_D) begin
            levels_r <= avm_readdata[KEY_W-1:0];
        end
    end

    assign fifo_full = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign evt_valid = (count != '0);
    assign do_pop    = evt_valid && evt_ready;
    // Spurious interrupts (no capture bits) are dropped here.
    assign do_push   = (state == PUSH) && (edges_r != '0) && (!fifo_full || do_pop);

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    assign head_entry = fifo_mem[rd_ptr];
    assign evt_edges  = evt_valid ? head_entry[KEY_W +: KEY_W] : '0;
    assign evt_level  = evt_valid ? head_entry[0 +: KEY_W] : '0;

endmodule

// File: tb/tb_key_evt_master.sv
// Bench for key_evt_master: a small behavioural model of the key PIO,
// directed steps for reset, latency, FIFO-full, mask priority and
// mid-operation reset, plus random key-fall patterns against an event queue.
module tb_key_evt_master;

    logic        clk;
    logic        reset_n;
    logic        irq;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic        mask_busy;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_edges;
    logic [3:0]  evt_level;
`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0] evt_time;
    logic [15:0] ts_q[$];
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];   // {edges, levels} in expected pop order

    key_evt_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .irq            (irq),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .mask_wr        (mask_wr),
        .mask_data      (mask_data),
        .mask_busy      (mask_busy),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level)
`ifdef KEY_EVT_TIMESTAMP_EN
        ,
        .evt_time       (evt_time)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key PIO model: registered read data, falling-edge capture, write clears.
    logic [3:0] keys, keys_prev, pio_mask, pio_edge;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys_prev    <= 4'hF;
            pio_mask     <= 4'h0;
            pio_edge     <= 4'h0;
            avm_readdata <= 32'd0;
        end else begin
            keys_prev <= keys;
            case (avm_address)
                2'd0:    avm_readdata <= {28'd0, keys};
                2'd2:    avm_readdata <= {28'd0, pio_mask};
                2'd3:    avm_readdata <= {28'd0, pio_edge};
                default: avm_readdata <= 32'd0;
            endcase
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
                pio_mask <= avm_writedata[3:0];
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
                pio_edge <= keys_prev & ~keys;
            else
                pio_edge <= pio_edge | (keys_prev & ~keys);
        end
    end
    assign irq = |(pio_edge & pio_mask);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Consumer side: every accepted event must match the oldest expected one.
    always begin
        @(negedge clk);
        #1;
        if (reset_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_expected_event", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("pop_edges", 32'(evt_edges), 32'(e[7:4]));
                chk("pop_level", 32'(evt_level), 32'(e[3:0]));
            end
`ifdef KEY_EVT_TIMESTAMP_EN
            ts_q.push_back(evt_time);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int w;
    logic [3:0] m;
    logic [2:0] pat [5];

    initial begin
        reset_n = 1'b0; keys = 4'hF; mask_wr = 1'b0; mask_data = 4'h0; evt_ready = 1'b0;
        pat[0] = 3'b000; pat[1] = 3'b001; pat[2] = 3'b011; pat[3] = 3'b111; pat[4] = 3'b111;
        tick(3);
        // Reset values
        chk("rst_cs",    32'(avm_chipselect), 32'd0);
        chk("rst_wn",    32'(avm_write_n),    32'd1);
        chk("rst_addr",  32'(avm_address),    32'd0);
        chk("rst_wd",    avm_writedata,       32'd0);
        chk("rst_valid", 32'(evt_valid),      32'd0);
        chk("rst_edges", 32'(evt_edges),      32'd0);
        chk("rst_level", 32'(evt_level),      32'd0);
        chk("rst_busy",  32'(mask_busy),      32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        // INIT mask write in the first cycle after release
        chk("init_cs",   32'(avm_chipselect), 32'd1);
        chk("init_wn",   32'(avm_write_n),    32'd0);
        chk("init_addr", 32'(avm_address),    32'd2);
        chk("init_wd",   avm_writedata,       32'hF);
        @(negedge clk);
        chk("idle_cs",    32'(avm_chipselect), 32'd0);
        chk("idle_wn",    32'(avm_write_n),    32'd1);
        chk("idle_mask",  32'(pio_mask),       32'hF);
        chk("idle_valid", 32'(evt_valid),      32'd0);

        // Key 1 falls: latency and clear write
        evt_ready = 1'b1;
        tick(3);
        keys = 4'hD;
        exp_q.push_back({4'h2, 4'hD});
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) chk("lat_cap_addr", 32'(avm_address), 32'd3);
            if (i == 4) begin
                chk("lat_clr_cs",   32'(avm_chipselect), 32'd1);
                chk("lat_clr_wn",   32'(avm_write_n),    32'd0);
                chk("lat_clr_addr", 32'(avm_address),    32'd3);
                chk("lat_clr_wd",   avm_writedata,       32'd0);
            end
            if (i == 5) chk("lat_irq_drop", 32'(irq), 32'd0);
            if (i == 7) chk("lat_valid_early", 32'(evt_valid), 32'd0);
            if (i == 8) begin
                chk("lat_valid", 32'(evt_valid), 32'd1);
                chk("lat_edges", 32'(evt_edges), 32'h2);
                chk("lat_level", 32'(evt_level), 32'hD);
            end
        end
        tick(4);
        chk("lat_drained", 32'(exp_q.size()), 32'd0);
        keys = 4'hF;
        tick(3);

        // FIFO full: four queued, fifth held in the PIO
        keys = 4'h1;
        exp_q.push_back({4'hE, 4'h1});
        tick(14);
        chk("full_pre_drain", 32'(exp_q.size()), 32'd0);
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keys = {pat[i], 1'b1};
            tick(3);
            keys = {pat[i], 1'b0};
            exp_q.push_back({4'h1, pat[i], 1'b0});
            tick(14);
        end
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("full_no_bus", 32'(avm_chipselect), 32'd0);
            chk("full_irq",    32'(irq),            32'd1);
        end
        chk("full_head_edges", 32'(evt_edges), 32'h1);
        chk("full_head_level", 32'(evt_level), 32'h0);
        evt_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 80) begin
            @(negedge clk);
            w++;
        end
        chk("full_drain", 32'(exp_q.size()), 32'd0);
        tick(2);
        chk("full_empty", 32'(evt_valid), 32'd0);
        keys = 4'hF;
        tick(3);

        // Mask request in the same cycle irq rises
        keys = 4'hE;
        exp_q.push_back({4'h1, 4'hE});
        @(negedge clk);
        chk("msk_irq_up", 32'(irq), 32'd1);
        mask_wr = 1'b1; mask_data = 4'h1;
        @(negedge clk);
        mask_wr = 1'b0;
        chk("msk_cs",   32'(avm_chipselect), 32'd1);
        chk("msk_wn",   32'(avm_write_n),    32'd0);
        chk("msk_addr", 32'(avm_address),    32'd2);
        chk("msk_wd",   avm_writedata,       32'h1);
        chk("msk_busy", 32'(mask_busy),      32'd1);
        @(negedge clk);
        chk("msk_cs_off", 32'(avm_chipselect), 32'd0);
        chk("msk_busy_off", 32'(mask_busy),    32'd0);
        chk("msk_pio",    32'(pio_mask),       32'h1);
        @(negedge clk);
        chk("msk_then_cap", 32'(avm_address), 32'd3);
        tick(12);
        chk("msk_drained", 32'(exp_q.size()), 32'd0);
        keys = 4'hF;
        tick(2);
        mask_wr = 1'b1; mask_data = 4'hF;
        @(negedge clk);
        mask_wr = 1'b0;
        chk("msk2_busy", 32'(mask_busy), 32'd1);
        chk("msk2_wd",   avm_writedata,  32'hF);
        @(negedge clk);
        chk("msk2_busy_off", 32'(mask_busy), 32'd0);
        chk("msk2_pio",      32'(pio_mask),  32'hF);

        // Reset during CLR
        evt_ready = 1'b0;
        keys = 4'hE;
        exp_q.push_back({4'h1, 4'hE});
        tick(14);
        chk("rr_one_queued", 32'(evt_valid), 32'd1);
        keys = 4'hF;
        tick(3);
        keys = 4'h7;
        tick(4);
        chk("rr_in_clr", 32'(avm_chipselect), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rr_cs",    32'(avm_chipselect), 32'd0);
        chk("rr_wn",    32'(avm_write_n),    32'd1);
        chk("rr_addr",  32'(avm_address),    32'd0);
        chk("rr_wd",    avm_writedata,       32'd0);
        chk("rr_valid", 32'(evt_valid),      32'd0);
        exp_q.delete();
        keys = 4'hF;
        tick(2);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rr_init_cs",   32'(avm_chipselect), 32'd1);
        chk("rr_init_addr", 32'(avm_address),    32'd2);
        chk("rr_init_wd",   avm_writedata,       32'hF);
        @(negedge clk);
        chk("rr_empty", 32'(evt_valid), 32'd0);
        tick(2);

        // Random key-fall patterns with a randomly stalling consumer
        for (int it = 0; it < 24; it++) begin
            m = 4'($urandom_range(1, 15));
            keys = 4'hF;
            tick(3);
            keys = ~m;
            exp_q.push_back({m, ~m});
            for (int c = 0; c < 16; c++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            evt_ready = 1'b1;
            w = 0;
            while (exp_q.size() != 0 && w < 30) begin
                @(negedge clk);
                w++;
            end
            chk("rnd_drain", 32'(exp_q.size()), 32'd0);
        end
        keys = 4'hF;
        tick(3);

`ifdef KEY_EVT_TIMESTAMP_EN
        // Two edges exactly 100 cycles apart
        ts_q.delete();
        keys = 4'hE;
        exp_q.push_back({4'h1, 4'hE});
        tick(50);
        keys = 4'hF;
        tick(50);
        keys = 4'hE;
        exp_q.push_back({4'h1, 4'hE});
        tick(20);
        chk("ts_count", 32'(ts_q.size()), 32'd2);
        if (ts_q.size() == 2)
            chk("ts_delta", 32'(16'(ts_q[1] - ts_q[0])), 32'd100);
        keys = 4'hF;
        tick(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_evt_master.md
# key_evt_master

Avalon-MM initiator that services the 4-bit key PIO. It sits next to the key PIO, reacts to its `irq`, reads and clears the edge-capture register, and samples the live key levels. Each result becomes a timestamp-optional event in a small FIFO with a valid/ready output, so hardware consumers get key events without Nios software in the loop.

## Interface
- `KEY_W`, 4: key count; equals the PIO data width.
- `MASK_INIT`, 4'hF: value written to the PIO `irq_mask` after reset.
- `FIFO_DEPTH`, 4: event FIFO entries; a power of two, ≥2.
- `clk` in 1: clock.
- `reset_n` in 1: reset; asynchronous, active-low.
- `irq` in 1: PIO interrupt, level-sensitive.
- `avm_address` out 2: PIO word address (0 data, 2 irq_mask, 3 edge_capture).
- `avm_chipselect` out 1: write qualifier.
- `avm_write_n` out 1: active-low write strobe.
- `avm_writedata` out 32: write data.
- `avm_readdata` in 32: PIO read data; registered in the PIO from the address; valid the cycle after the address is presented; no waitrequest.
- `mask_wr` in 1: request to rewrite `irq_mask`; single-cycle pulse.
- `mask_data` in KEY_W: new mask value.
- `mask_busy` out 1: high while a mask write is pending.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_edges` out KEY_W: falling-edge bits captured at the head.
- `evt_level` out KEY_W: key levels sampled after the clear.

## Operation
- FSM states: INIT, IDLE, MASK, CAP_A, CAP_D, CLR, DAT_A, DAT_D, PUSH.
- INIT: issue one write cycle with address 2, writedata {28'b0, MASK_INIT}, chipselect=1, write_n=0. Then go to IDLE.
- IDLE, checked in priority order:
  - A pending mask request goes to MASK.
  - Otherwise, irq=1 with the FIFO not full goes to CAP_A.
  - Otherwise, stay in IDLE.
- MASK: write address 2 with the latched mask_data, clear the pending request, go to IDLE.
- A mask_wr pulse is latched in any state. A second pulse before service overwrites the latched data.
- CAP_A: address=3, no write. CAP_D: capture avm_readdata[KEY_W-1:0] as edges.
- CLR: write address 3, writedata 0. This clears all capture bits.
  - Edges arriving between CAP_D and CLR are lost. This 2-cycle window is accepted.
- DAT_A: address=0. DAT_D: capture the levels.
- PUSH: if edges≠0, push {edges, levels} into the FIFO. If edges=0 (spurious), drop it. Go to IDLE.
- FIFO full: IDLE does not service irq. Edges keep accumulating (OR-merged) in the PIO, so none are lost; they are serviced once a slot frees.
- Pop happens when evt_valid && evt_ready. A push and pop in the same cycle keep the count unchanged.
- Outside write cycles: avm_chipselect=0, avm_write_n=1. avm_address holds its last value.

## Timing
- Reset values:
  - Bus outputs: avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - Stream and control outputs: evt_valid=0, evt_edges=0, evt_level=0, mask_busy=0.
  - FIFO: empty. FSM: INIT.
- INIT write occurs in the first cycle after reset release.
- irq sampled high in IDLE at edge t:
  - CAP_A in t+1, CAP_D t+2, CLR t+3, DAT_A t+4, DAT_D t+5, PUSH t+6.
  - With the FIFO empty, evt_valid=1 in cycle t+7.
- The PIO irq drops the cycle after CLR. No retrigger from a stale irq is possible because IDLE is entered at t+7.
- mask_busy rises the cycle after mask_wr and falls the cycle after MASK.
- Reset mid-operation: everything returns to reset values and the FIFO is flushed. Because the PIO shares reset_n, INIT re-runs.
- FIFO head data is don't-care while evt_valid=0.

## Configuration
- `KEY_EVT_TIMESTAMP_EN` defined:
  - Adds a free-running 16-bit cycle counter (reset 0, wraps at 16'hFFFF→0).
  - Adds output `evt_time` [15:0] and widens the FIFO entry.
  - The counter value is captured in CAP_D and travels with the event; reset value 0.
- Undefined: no counter, no `evt_time` port, FIFO entry is 2×KEY_W bits.

## Test plan
- Reset release → one write at address 2 with data 0xF in cycle 1; then bus idle, evt_valid=0.
- Key 1 falls (PIO in_port 0xF→0xD), evt_ready=1 → edge_capture write at address 3 → event edges=0x2, level=0xD, evt_valid 7 cycles after irq is sampled.
- evt_ready=0, five separate edges on key 0 → 4 events queued; a fifth is not serviced (irq stays high, no bus traffic). Raise evt_ready → the 4 pop in order, then the fifth edge is serviced.
- mask_wr with mask_data=0x1 asserted in the same cycle irq rises → MASK write (address 2, data 0x1) precedes CAP_A.
- reset_n pulsed low during CLR → bus outputs are at reset values immediately, FIFO empty, INIT write follows release.
- With `KEY_EVT_TIMESTAMP_EN`: two edges 100 cycles apart → evt_time values differ by exactly 100.
